tlc_multiphase: RTL

Parametrised N-approach traffic light controller with its own elapsed-time counter. It generalises the two-approach controller to `N_PHASES` approaches with per-phase vehicle sensing and latched demand, minimum/maximum green, yellow and all-red clearance intervals, and round-robin service. It sits at the top of an intersection design and drives one red/yellow/green lamp triple per approach.

---
 rtl/tlc_pkg.sv | 10 +
 rtl/tlc_timer.sv | 16 +
 rtl/tlc_multiphase.sv | 113 +++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding and phase-index width helper for the traffic light controller
package tlc_pkg;

   typedef enum logic [1:0] {GREEN, YELLOW, ALLRED} tlc_state_t;

   function automatic int PH_W(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tlc_timer.sv
// tlc_timer: TW-bit saturating up-counter with synchronous clear and asynchronous active-low reset
module tlc_timer #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          res_n,
   input  logic          clr,
   output logic [TW-1:0] t
);

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) t <= '0;
      else if (clr) t <= '0;
      else if (~&t) t <= t + 1'b1;

endmodule

// File: rtl/tlc_multiphase.sv
// tlc_multiphase: N-approach round-robin traffic light controller with demand latching.
// Define TLC_PED_EN to add pedestrian request inputs and walk outputs.
module tlc_multiphase
   import tlc_pkg::*;
#(
   parameter int N_PHASES  = 4,
   parameter int TW        = 8,
   parameter int GREEN_MIN = 10,
   parameter int GREEN_MAX = 40,
   parameter int YELLOW_T  = 4,
`ifdef TLC_PED_EN
   parameter int WALK_T    = 8,
`endif
   parameter int ALLRED_T  = 2
) (
   input  logic                          clk,
   input  logic                          res_n,
   input  logic [N_PHASES-1:0]           sense,
`ifdef TLC_PED_EN
   input  logic [N_PHASES-1:0]           ped_req,
   output logic [N_PHASES-1:0]           walk,
`endif
   output logic [N_PHASES-1:0]           green,
   output logic [N_PHASES-1:0]           yellow,
   output logic [N_PHASES-1:0]           red,
   output logic [PH_W(N_PHASES)-1:0]     phase,
   output logic [TW-1:0]                 t
);

   localparam int PW = PH_W(N_PHASES);
   localparam logic [N_PHASES-1:0] ONE = 1;

   tlc_state_t state, state_nxt;
   logic [PW-1:0] nxt;
   logic [N_PHASES-1:0] dem, dem_set, dem_clr, cur_oh;
   logic others, go_yellow, end_yellow, end_allred, enter_green;

   // first phase after p, in round-robin order, with demand; lowest offset wins
   function automatic logic [PW-1:0] rr_pick(input logic [N_PHASES-1:0] d, input logic [PW-1:0] p);
      rr_pick = p;
      for (int k = N_PHASES - 1; k >= 1; k--)
         if (d[(int'(p) + k) % N_PHASES]) rr_pick = PW'((int'(p) + k) % N_PHASES);
   endfunction

   tlc_timer #(.TW(TW)) u_timer (
      .clk   (clk),
      .res_n (res_n),
      .clr   (state_nxt != state),
      .t     (t)
   );

   always_comb begin
      cur_oh      = ONE << phase;
      others      = |(dem & ~cur_oh);
      go_yellow   = t >= TW'(GREEN_MIN - 1) && others && (!sense[phase] || t >= TW'(GREEN_MAX - 1));
      end_yellow  = t == TW'(YELLOW_T - 1);
      end_allred  = t == TW'(ALLRED_T - 1);
      enter_green = state == ALLRED && end_allred;
   end

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) state <= GREEN;
      else state <= state_nxt;

   always_comb
      state_nxt = (state == GREEN  && go_yellow)  ? YELLOW :
                  (state == YELLOW && end_yellow) ? ALLRED :
                  enter_green                     ? GREEN  : state;

   always_comb begin
      green  = (state == GREEN)  ? cur_oh : '0;
      yellow = (state == YELLOW) ? cur_oh : '0;
      red    = ~(green | yellow);
   end

   // the phase entering green drops its own demand even if its sensor is still high
   always_comb begin
      dem_clr = enter_green ? ONE << nxt : '0;
      dem_set = sense & ~((state == GREEN) ? cur_oh : '0);
`ifdef TLC_PED_EN
      dem_set = dem_set | ped_req;
`endif
   end

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
         dem   <= '0;
         nxt   <= '0;
         phase <= '0;
      end else begin
         dem   <= (dem | dem_set) & ~dem_clr;
         nxt   <= (state == GREEN && go_yellow) ? rr_pick(dem, phase) : nxt;
         phase <= enter_green ? nxt : phase;
      end

`ifdef TLC_PED_EN
   logic [N_PHASES-1:0] pdem;
   logic walk_ok;

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
         pdem    <= '0;
         walk_ok <= 1'b0;
      end else begin
         pdem    <= (pdem | ped_req) & ~dem_clr;
         walk_ok <= enter_green ? pdem[nxt] : walk_ok;
      end

   always_comb
      walk = (state == GREEN && walk_ok && t < TW'(WALK_T)) ? cur_oh : '0;
`endif

endmodule
